// File: rtl/serve_button_conditioner.sv
`default_nettype none
// +------------------------------------------------------------------------------------+
// | Module   : serve_button_conditioner                                                |
// | Purpose  : Two-channel serve pushbutton synchroniser, debouncer and edge-to-pulse  |
// |            conditioner. Optional macro SERVE_TURN_EN enforces alternating serves.  |
// | Revision : 1.0 - initial release                                                   |
// +------------------------------------------------------------------------------------+
module serve_button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int SYNC_STAGES     = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_player1_raw,
   input  logic       btn_player2_raw,
   input  logic       serve_enable,
   output logic       serve_button_player1,
   output logic       serve_button_player2,
   output logic [1:0] btn_level,
   output logic       serve_turn
);

   localparam int                 c_cnt_w    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

   logic [1:0] w_raw;
   logic [1:0] w_stable;
   logic [1:0] r_stable_d;
   logic [1:0] w_rise;
   logic [1:0] w_allow;
   logic       w_fire1;
   logic       w_fire2;
   logic       r_pulse1;
   logic       r_pulse2;

   assign w_raw = {btn_player2_raw, btn_player1_raw};

   generate
      for (genvar g = 0; g < 2; g++) begin : g_chan
         logic [SYNC_STAGES-1:0] r_sync;
         logic [c_cnt_w-1:0]     r_cnt;
         logic                   r_stable;

         // Any sample matching the stable level restarts the count, so only an
         // unbroken run of DEBOUNCE_CYCLES differing samples is accepted.
         always_ff @(posedge clk) begin
            if (reset) begin
               r_sync   <= '0;
               r_cnt    <= '0;
               r_stable <= 1'b0;
            end else begin
               r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[g]};
               if (r_sync[SYNC_STAGES-1] == r_stable) begin
                  r_cnt <= '0;
               end else if (r_cnt == c_cnt_last) begin
                  r_stable <= r_sync[SYNC_STAGES-1];
                  r_cnt    <= '0;
               end else begin
                  r_cnt <= r_cnt + c_cnt_w'(1);
               end
            end
         end

         assign w_stable[g] = r_stable;
      end
   endgenerate

   assign w_rise = w_stable & ~r_stable_d;

`ifdef SERVE_TURN_EN
   logic r_turn;
   assign w_allow    = {r_turn, ~r_turn};
   assign serve_turn = r_turn;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_turn <= 1'b0;
      end else if (r_pulse1 || r_pulse2) begin
         r_turn <= ~r_turn;
      end
   end
`else
   assign w_allow    = 2'b11;
   assign serve_turn = 1'b0;
`endif

   // Player 1 wins a same-cycle tie; with turn gating the allows are exclusive anyway.
   assign w_fire1 = w_rise[0] & serve_enable & w_allow[0];
   assign w_fire2 = w_rise[1] & serve_enable & w_allow[1] & ~w_fire1;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stable_d <= 2'b00;
         r_pulse1   <= 1'b0;
         r_pulse2   <= 1'b0;
      end else begin
         r_stable_d <= w_stable;
         r_pulse1   <= w_fire1;
         r_pulse2   <= w_fire2;
      end
   end

   assign serve_button_player1 = r_pulse1;
   assign serve_button_player2 = r_pulse2;
   assign btn_level            = w_stable;

endmodule
`default_nettype wire
